// File: rtl/ama_riscv_perf_mon.sv
// Run-level performance monitor: cycle/instruction/event counters gated by a pass/fail/timeout FSM.
// Optional watchdog and TIMEOUT state are built only when AMA_RISCV_PERF_MON_TIMEOUT_EN is defined.
module ama_riscv_perf_mon #(
    parameter int CNT_W  = 64,
    parameter int NUM_EV = 4,
    parameter int TMO_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                inst_wb_nop_or_clear,
    input  logic [NUM_EV-1:0]   ev_in,
    input  logic [31:0]         csr_tohost,
    input  logic                mmio_reset_cnt,
    input  logic [TMO_W-1:0]    timeout_limit,
    input  logic [4:0]          rd_sel,
    output logic [CNT_W-1:0]    rd_data,
    output logic [NUM_EV+1:0]   ovf,
    output logic [2:0]          state,
    output logic [30:0]         fail_code
);
    localparam int NCNT = NUM_EV + 2;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_PASS    = 3'd2;
    localparam logic [2:0] S_FAIL    = 3'd3;
    localparam logic [2:0] S_TIMEOUT = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt [NCNT];
    logic [NCNT-1:0]  r_ovf;
    logic [30:0]      r_fail_code;
    logic [CNT_W-1:0] r_rd_data;
    logic [CNT_W-1:0] w_rd_mux;
    logic             w_run;
    logic             w_done;
    logic             w_timeout;
    logic [NCNT-1:0]  w_inc;

    assign w_run  = (r_state == S_RUN);
    assign w_done = w_run && csr_tohost[0];
    // Counter index order: 0 cycles, 1 retired instructions, 2.. generic events.
    assign w_inc  = w_run ? {ev_in, ~inst_wb_nop_or_clear, 1'b1} : '0;

`ifdef AMA_RISCV_PERF_MON_TIMEOUT_EN
    logic [TMO_W-1:0] r_wdog;
    logic [TMO_W-1:0] w_wdog_cur;

    // r_wdog holds completed RUN cycles; the compared count includes the current cycle.
    assign w_wdog_cur = (&r_wdog) ? r_wdog : r_wdog + 1'b1;
    assign w_timeout  = w_run && (timeout_limit != '0) && (w_wdog_cur == timeout_limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_wdog <= '0;
        end else if (w_run) begin
            r_wdog <= w_wdog_cur;
        end
    end
`else
    logic w_unused_tmo;

    assign w_unused_tmo = ^timeout_limit;
    assign w_timeout    = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_done) w_state_nxt = (csr_tohost == 32'd1) ? S_PASS : S_FAIL;
                else if (w_timeout) w_state_nxt = S_TIMEOUT;
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fail_code <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_done) r_fail_code <= csr_tohost[31:1];
        end
    end

    // Counter clear wins over any increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || mmio_reset_cnt) begin
            for (int i = 0; i < NCNT; i++) r_cnt[i] <= '0;
            r_ovf <= '0;
        end else begin
            for (int i = 0; i < NCNT; i++) begin
                if (w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                    if (&r_cnt[i]) r_ovf[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (rd_sel == 5'(i)) w_rd_mux = r_cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_rd_data <= '0;
        else     r_rd_data <= w_rd_mux;
    end

    assign rd_data   = r_rd_data;
    assign ovf       = r_ovf;
    assign state     = r_state;
    assign fail_code = r_fail_code;

endmodule

// File: doc/ama_riscv_perf_mon.md
AMA_RISCV_PERF_MON -- requirements
Module: ama_riscv_perf_mon

Interface
REQ-001 SHALL have parameter CNT_W, default 64, width of every counter.
REQ-002 SHALL have parameter NUM_EV, default 4, number of generic event counters (1..16).
REQ-003 SHALL have parameter TMO_W, default 32, width of watchdog limit and counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse, begins a run.
REQ-007 SHALL have port inst_wb_nop_or_clear  input  1  high when writeback slot holds no retired instruction.
REQ-008 SHALL have port ev_in  input  NUM_EV  per-cycle event strobes.
REQ-009 SHALL have port csr_tohost  input  32  tohost CSR value.
REQ-010 SHALL have port mmio_reset_cnt  input  1  clears all counters.
REQ-011 SHALL have port timeout_limit  input  TMO_W  watchdog limit in cycles; 0 disables the watchdog.
REQ-012 SHALL have port rd_sel  input  5  counter select: 0 cycles, 1 instructions, 2..NUM_EV+1 events.
REQ-013 SHALL have port rd_data  output  CNT_W  selected counter, registered.
REQ-014 SHALL have port ovf  output  NUM_EV+2  sticky per-counter wrap flags, same index order as rd_sel.
REQ-015 SHALL have port state  output  3  FSM state encoding.
REQ-016 SHALL have port fail_code  output  31  csr_tohost[31:1] captured at completion.

Function
REQ-017 SHALL implement states IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4.
REQ-018 IDLE -> RUN on start; start in any other state SHALL be ignored.
REQ-019 RUN -> PASS when csr_tohost[0]=1 and csr_tohost==32'd1; RUN -> FAIL when csr_tohost[0]=1 and csr_tohost!=1, capturing fail_code in the same edge.
REQ-020 RUN -> TIMEOUT when watchdog count equals timeout_limit (nonzero); tohost completion in the same cycle SHALL take priority.
REQ-021 PASS, FAIL, TIMEOUT SHALL be terminal until rst.
REQ-022 Counters SHALL increment only in RUN: cycles every cycle, instructions when inst_wb_nop_or_clear=0, event i when ev_in[i]=1; frozen in all other states.
REQ-023 The edge leaving RUN SHALL still count that final cycle's events.
REQ-024 Counters SHALL wrap modulo 2^CNT_W; on wrap the matching ovf bit SHALL set and stay set until rst or mmio_reset_cnt.
REQ-025 mmio_reset_cnt SHALL zero all counters and ovf next edge, overriding any same-cycle increment; it SHALL NOT change state or the watchdog.
REQ-026 Watchdog SHALL clear on entering RUN and increment every RUN cycle, saturating at all-ones.
REQ-027 rd_data SHALL reflect the counter value at the previous edge selected by rd_sel, one-cycle latency; out-of-range rd_sel SHALL return 0.

Reset
REQ-028 On rst: state=IDLE, all counters, watchdog, ovf, fail_code and rd_data = 0.
REQ-029 rst asserted mid-RUN SHALL abort the run with reset values next edge; start in the same cycle as rst SHALL be ignored.

Configuration
REQ-030 Macro AMA_RISCV_PERF_MON_TIMEOUT_EN: defined -> watchdog and TIMEOUT state per REQ-020/026; undefined -> no watchdog logic, timeout_limit ignored, TIMEOUT unreachable, state never 4.

Verification
REQ-031 Reset, start, 10 cycles with inst_wb_nop_or_clear alternating 0/1, then csr_tohost=1 -> state=PASS, cycles=11, instructions=6 (incl. final cycle), fail_code=0.
REQ-032 Run, then csr_tohost=32'h0000_0007 -> state=FAIL, fail_code=3, counters frozen over next 20 cycles.
REQ-033 With TIMEOUT_EN, timeout_limit=50, no tohost -> state=TIMEOUT after 50 RUN cycles; with tohost=1 at cycle 50 -> PASS instead.
REQ-034 CNT_W=8, ev_in[0] high 300 RUN cycles -> event0=44, ovf[2]=1; mmio_reset_cnt pulse with ev_in[0]=1 -> event0=0, ovf=0.
REQ-035 rst asserted mid-RUN after 30 cycles -> next edge state=IDLE, all outputs 0; new start restarts counting from 0.
REQ-036 rd_sel sweep 0..NUM_EV+2 -> each counter one cycle later, NUM_EV+2 returns 0.
